id_pipe: RTL and testbench

Pipelined, parametrised instruction-decode stage for the RV32I core. It decodes all base formats and holds an integrated register file with optional write-back bypass. A per-register scoreboard interlocks RAW/WAW hazards, and results go out through a registered ID/EX slice with valid/ready handshakes on both sides. It sits between IF and EX and replaces the single-cycle decode path.

---
 rtl/id_pkg.sv | 81 ++++++++
 rtl/id_regfile.sv | 40 ++++
 rtl/id_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_id_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU codes, immediate
// formats and the ID/EX slice payload.
package id_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RIDX  = 5;
  localparam int unsigned ALU_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [ALU_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'b10000;
  localparam logic [ALU_W-1:0] ALU_SLL  = 5'b00100;
  localparam logic [ALU_W-1:0] ALU_SLT  = 5'b10111;
  localparam logic [ALU_W-1:0] ALU_SLTU = 5'b11000;
  localparam logic [ALU_W-1:0] ALU_XOR  = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_SRL  = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_SRA  = 5'b00110;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'b00010;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'b00001;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [RIDX-1:0]  rd;
    logic [2:0]       funct3;
    logic [ALU_W-1:0] alu_ctrl;
    logic             alu_src;
    logic             regwrite;
    logic             memwrite;
    logic             memtoreg;
    logic             jal;
    logic             jalr;
    logic             branch;
    logic             lui;
    logic             auipc;
    logic             illegal;
  } id_ex_t;

  function automatic logic [XLEN-1:0] gen_imm(input logic [XLEN-1:0] inst, input imm_fmt_e fmt);
    logic [XLEN-1:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // alt selects SUB over ADD and SRA over SRL (funct7[5])
  function automatic logic [ALU_W-1:0] alu_op(input logic [2:0] funct3, input logic alt);
    logic [ALU_W-1:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: unreset storage, hard-wired x0 and optional
// same-cycle write-back forwarding on both read ports.
module id_regfile
  import id_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic [RIDX-1:0] rs1,
  input  logic [RIDX-1:0] rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] mem [NREG];
  logic            wr;

  assign wr = wb_en && (wb_rd != '0) && (32'(wb_rd) < NREG);

  always_ff @(posedge clk) begin
    if (wr) mem[wb_rd[AW-1:0]] <= wb_data;
  end

  // x0 overrides the bypass, which overrides storage
  always_comb begin
    rs1_data = mem[rs1[AW-1:0]];
    rs2_data = mem[rs2[AW-1:0]];
    if (BYPASS && wb_en && (wb_rd == rs1)) rs1_data = wb_data;
    if (BYPASS && wb_en && (wb_rd == rs2)) rs2_data = wb_data;
    if (rs1 == '0) rs1_data = '0;
    if (rs2 == '0) rs2_data = '0;
  end

endmodule

// File: rtl/id_pipe.sv
// RV32I instruction-decode stage: decoder, scoreboard interlock and a
// registered ID/EX slice with valid/ready on both sides.
module id_pipe
  import id_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [XLEN-1:0]  i_inst,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_flush,
  input  logic             i_wb_en,
  input  logic [RIDX-1:0]  i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_pc,
  output logic [XLEN-1:0]  o_rs1_data,
  output logic [XLEN-1:0]  o_rs2_data,
  output logic [XLEN-1:0]  o_imm,
  output logic [RIDX-1:0]  o_rd,
  output logic [2:0]       o_funct3,
  output logic [ALU_W-1:0] o_alu_ctrl,
  output logic             o_alu_src,
  output logic             o_regwrite,
  output logic             o_memwrite,
  output logic             o_memtoreg,
  output logic             o_jal,
  output logic             o_jalr,
  output logic             o_branch,
  output logic             o_lui,
  output logic             o_auipc,
  output logic             o_illegal
);

  localparam bit RV32E = (NREG == 16);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RIDX-1:0] rs1, rs2, rd;

  assign opcode = i_inst[6:0];
  assign rd     = i_inst[11:7];
  assign funct3 = i_inst[14:12];
  assign rs1    = i_inst[19:15];
  assign rs2    = i_inst[24:20];
  assign funct7 = i_inst[31:25];

  imm_fmt_e         imm_fmt;
  logic             use_rs1, use_rs2, use_rd, bad_enc, bad_reg, illegal, regwrite;
  logic             alu_src;
  logic [ALU_W-1:0] alu;

  // Per-opcode operand usage, immediate format and encoding legality
  always_comb begin
    imm_fmt = IMM_NONE;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    bad_enc = 1'b0;
    alu_src = 1'b0;
    alu     = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        alu = alu_op(funct3, funct7[5]);
        if (funct7 == 7'b0100000) bad_enc = !((funct3 == 3'b000) || (funct3 == 3'b101));
        else                      bad_enc = (funct7 != 7'b0000000);
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1; use_rd = 1'b1; alu_src = 1'b1; imm_fmt = IMM_I;
        alu = alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001)      bad_enc = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101) bad_enc = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1; use_rd = 1'b1; alu_src = 1'b1; imm_fmt = IMM_I;
        bad_enc = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; alu_src = 1'b1; imm_fmt = IMM_S;
        bad_enc = (funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm_fmt = IMM_B; alu = ALU_SUB;
        bad_enc = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JAL: begin
        use_rd = 1'b1; imm_fmt = IMM_J;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1; use_rd = 1'b1; alu_src = 1'b1; imm_fmt = IMM_I;
        bad_enc = (funct3 != 3'b000);
      end
      OPC_LUI, OPC_AUIPC: begin
        use_rd = 1'b1; alu_src = 1'b1; imm_fmt = IMM_U;
      end
      default: bad_enc = 1'b1;
    endcase
  end

  assign bad_reg  = RV32E && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]));
  assign illegal  = bad_enc || bad_reg;
  assign regwrite = use_rd && !illegal;

  id_ex_t          dec, slice;
  logic [XLEN-1:0] rs1_data, rs2_data;

  id_regfile #(.NREG(NREG), .BYPASS(BYPASS)) u_regfile (
    .clk     (i_clk),
    .rs1     (rs1),
    .rs2     (rs2),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .wb_en   (i_wb_en),
    .wb_rd   (i_wb_rd),
    .wb_data (i_wb_data)
  );

  always_comb begin
    dec          = '0;
    dec.pc       = i_pc;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.imm      = gen_imm(i_inst, imm_fmt);
    dec.rd       = use_rd ? rd : '0;
    dec.funct3   = funct3;
    dec.alu_ctrl = alu;
    dec.alu_src  = alu_src;
    dec.regwrite = regwrite;
    dec.memwrite = (opcode == OPC_STORE) && !illegal;
    dec.memtoreg = (opcode == OPC_LOAD);
    dec.jal      = (opcode == OPC_JAL);
    dec.jalr     = (opcode == OPC_JALR);
    dec.branch   = (opcode == OPC_BRANCH);
    dec.lui      = (opcode == OPC_LUI);
    dec.auipc    = (opcode == OPC_AUIPC);
    dec.illegal  = illegal;
  end

  logic [NREG-1:1] busy, busy_nxt;
  logic [31:0]     busy_eff;
  logic            hazard, issue, valid_q;

  // With bypass a register being written back this cycle no longer blocks
  always_comb begin
    busy_eff = '0;
    for (int i = 1; i < int'(NREG); i++)
      busy_eff[i] = busy[i] && !(BYPASS && i_wb_en && (i_wb_rd == 5'(i)));
  end

  assign hazard  = (use_rs1 && busy_eff[rs1]) || (use_rs2 && busy_eff[rs2]) ||
                   (regwrite && busy_eff[rd]);
  assign o_ready = !hazard && !i_flush && (!valid_q || i_ready);
  assign issue   = i_valid && o_ready;

  // Clears first so a same-cycle set on the same register wins
  always_comb begin
    busy_nxt = busy;
    for (int i = 1; i < int'(NREG); i++) begin
      if (i_wb_en && (i_wb_rd == 5'(i))) busy_nxt[i] = 1'b0;
      if (i_flush && valid_q && slice.regwrite && (slice.rd == 5'(i))) busy_nxt[i] = 1'b0;
      if (issue && regwrite && (rd == 5'(i))) busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      slice   <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (issue) begin
      valid_q <= 1'b1;
      slice   <= dec;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid    = valid_q;
  assign o_pc       = slice.pc;
  assign o_rs1_data = slice.rs1_data;
  assign o_rs2_data = slice.rs2_data;
  assign o_imm      = slice.imm;
  assign o_rd       = slice.rd;
  assign o_funct3   = slice.funct3;
  assign o_alu_ctrl = slice.alu_ctrl;
  assign o_alu_src  = slice.alu_src;
  assign o_regwrite = slice.regwrite;
  assign o_memwrite = slice.memwrite;
  assign o_memtoreg = slice.memtoreg;
  assign o_jal      = slice.jal;
  assign o_jalr     = slice.jalr;
  assign o_branch   = slice.branch;
  assign o_lui      = slice.lui;
  assign o_auipc    = slice.auipc;
  assign o_illegal  = slice.illegal;

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: three instances (RV32I bypass, RV32I no bypass,
// RV32E bypass) share stimulus except for per-instance i_valid.
module tb_id_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid [3];
  logic [31:0] inst, pc, wb_data;
  logic        flush, wb_en, rdy_in;
  logic [4:0]  wb_rd;

  logic        ready_o [3];
  logic        valid_o [3];
  logic [31:0] pc_o [3];
  logic [31:0] rs1_o [3];
  logic [31:0] rs2_o [3];
  logic [31:0] imm_o [3];
  logic [4:0]  rd_o [3];
  logic [4:0]  alu_o [3];
  logic [2:0]  f3_o [3];
  logic        src_o [3];
  logic        rw_o [3];
  logic        mw_o [3];
  logic        mtr_o [3];
  logic        jal_o [3];
  logic        jalr_o [3];
  logic        br_o [3];
  logic        lui_o [3];
  logic        auipc_o [3];
  logic        ill_o [3];

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    id_pipe #(.NREG((g == 2) ? 16 : 32), .BYPASS((g == 1) ? 1'b0 : 1'b1)) u_dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_valid   (valid[g]),
      .o_ready   (ready_o[g]),
      .i_inst    (inst),
      .i_pc      (pc),
      .i_flush   (flush),
      .i_wb_en   (wb_en),
      .i_wb_rd   (wb_rd),
      .i_wb_data (wb_data),
      .o_valid   (valid_o[g]),
      .i_ready   (rdy_in),
      .o_pc      (pc_o[g]),
      .o_rs1_data(rs1_o[g]),
      .o_rs2_data(rs2_o[g]),
      .o_imm     (imm_o[g]),
      .o_rd      (rd_o[g]),
      .o_funct3  (f3_o[g]),
      .o_alu_ctrl(alu_o[g]),
      .o_alu_src (src_o[g]),
      .o_regwrite(rw_o[g]),
      .o_memwrite(mw_o[g]),
      .o_memtoreg(mtr_o[g]),
      .o_jal     (jal_o[g]),
      .o_jalr    (jalr_o[g]),
      .o_branch  (br_o[g]),
      .o_lui     (lui_o[g]),
      .o_auipc   (auipc_o[g]),
      .o_illegal (ill_o[g])
    );
  end

  localparam logic [31:0] ADDI_X1   = 32'h00500093;
  localparam logic [31:0] ADDI_X3   = 32'h00900193;
  localparam logic [31:0] ADD_X2    = 32'h00108133;
  localparam logic [31:0] ADD_X4    = 32'h00318233;
  localparam logic [31:0] BEQ_M8    = 32'hFE000CE3;
  localparam logic [31:0] ADDI_X17  = 32'h00100893;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic v0, input logic v1, input logic v2);
    valid[0] = v0; valid[1] = v1; valid[2] = v2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (valid_o[g] !== 1'b0) begin miscompares++; $display("FAIL reset_valid dut%0d got %b want 0", g, valid_o[g]); end
      vectors++;
      if (ready_o[g] !== 1'b1) begin miscompares++; $display("FAIL reset_ready dut%0d got %b want 1", g, ready_o[g]); end
      vectors++;
      if (imm_o[g] !== 32'h0 || pc_o[g] !== 32'h0 || rw_o[g] !== 1'b0 || alu_o[g] !== 5'h0) begin
        miscompares++;
        $display("FAIL reset_slice dut%0d got imm=%h pc=%h rw=%b alu=%b want zeros", g, imm_o[g], pc_o[g], rw_o[g], alu_o[g]);
      end
    end
  endtask

  task automatic test_decode();
    logic [31:0] v_inst [9];
    logic [4:0]  v_alu  [9];
    logic [31:0] v_imm  [9];
    logic        v_src  [9];
    logic        v_ill  [9];
    logic        v_rw   [9];
    logic        v_mw   [9];
    v_inst[0] = 32'h40735033; v_alu[0] = 5'b00110; v_imm[0] = 32'h0;        v_src[0] = 0; v_ill[0] = 0; v_rw[0] = 1; v_mw[0] = 0;
    v_inst[1] = 32'h40001033; v_alu[1] = 5'b00000; v_imm[1] = 32'h0;        v_src[1] = 0; v_ill[1] = 1; v_rw[1] = 0; v_mw[1] = 0;
    v_inst[2] = 32'h40305013; v_alu[2] = 5'b00110; v_imm[2] = 32'h403;      v_src[2] = 1; v_ill[2] = 0; v_rw[2] = 1; v_mw[2] = 0;
    v_inst[3] = 32'hFE002E23; v_alu[3] = 5'b00000; v_imm[3] = 32'hFFFFFFFC; v_src[3] = 1; v_ill[3] = 0; v_rw[3] = 0; v_mw[3] = 1;
    v_inst[4] = 32'h12345037; v_alu[4] = 5'b00000; v_imm[4] = 32'h12345000; v_src[4] = 1; v_ill[4] = 0; v_rw[4] = 1; v_mw[4] = 0;
    v_inst[5] = 32'h0080006F; v_alu[5] = 5'b00000; v_imm[5] = 32'h8;        v_src[5] = 0; v_ill[5] = 0; v_rw[5] = 1; v_mw[5] = 0;
    v_inst[6] = 32'h0000000B; v_alu[6] = 5'b00000; v_imm[6] = 32'h0;        v_src[6] = 0; v_ill[6] = 1; v_rw[6] = 0; v_mw[6] = 0;
    v_inst[7] = 32'h00002033; v_alu[7] = 5'b10111; v_imm[7] = 32'h0;        v_src[7] = 0; v_ill[7] = 0; v_rw[7] = 1; v_mw[7] = 0;
    v_inst[8] = 32'h00003033; v_alu[8] = 5'b11000; v_imm[8] = 32'h0;        v_src[8] = 0; v_ill[8] = 0; v_rw[8] = 1; v_mw[8] = 0;
    for (int i = 0; i < 9; i++) begin
      inst = v_inst[i];
      set_valid(1'b1, 1'b0, 1'b0);
      tick();
      set_valid(1'b0, 1'b0, 1'b0);
      vectors++;
      if (valid_o[0] !== 1'b1 || ill_o[0] !== v_ill[i] || rw_o[0] !== v_rw[i] || mw_o[0] !== v_mw[i]) begin
        miscompares++;
        $display("FAIL dec_flags vec%0d got v=%b ill=%b rw=%b mw=%b want v=1 ill=%b rw=%b mw=%b",
                 i, valid_o[0], ill_o[0], rw_o[0], mw_o[0], v_ill[i], v_rw[i], v_mw[i]);
      end
      vectors++;
      if (imm_o[0] !== v_imm[i] || src_o[0] !== v_src[i]) begin
        miscompares++;
        $display("FAIL dec_imm vec%0d got imm=%h src=%b want imm=%h src=%b", i, imm_o[0], src_o[0], v_imm[i], v_src[i]);
      end
      if (!v_ill[i]) begin
        vectors++;
        if (alu_o[0] !== v_alu[i]) begin miscompares++; $display("FAIL dec_alu vec%0d got %b want %b", i, alu_o[0], v_alu[i]); end
      end
    end
  endtask

  task automatic test_basic();
    inst = ADDI_X1; pc = 32'h100;
    set_valid(1'b1, 1'b1, 1'b1);
    #1;
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (ready_o[g] !== 1'b1) begin miscompares++; $display("FAIL basic_ready dut%0d got %b want 1", g, ready_o[g]); end
    end
    tick();
    set_valid(1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (valid_o[g] !== 1'b1 || rd_o[g] !== 5'd1 || imm_o[g] !== 32'd5 || pc_o[g] !== 32'h100) begin
        miscompares++;
        $display("FAIL basic_fields dut%0d got v=%b rd=%0d imm=%h pc=%h want v=1 rd=1 imm=5 pc=100", g, valid_o[g], rd_o[g], imm_o[g], pc_o[g]);
      end
      vectors++;
      if (alu_o[g] !== 5'b00000 || src_o[g] !== 1'b1 || rw_o[g] !== 1'b1 || ill_o[g] !== 1'b0 || rs1_o[g] !== 32'h0) begin
        miscompares++;
        $display("FAIL basic_ctrl dut%0d got alu=%b src=%b rw=%b ill=%b rs1=%h want 00000 1 1 0 0", g, alu_o[g], src_o[g], rw_o[g], ill_o[g], rs1_o[g]);
      end
    end
  endtask

  task automatic test_raw();
    inst = ADD_X2;
    set_valid(1'b1, 1'b1, 1'b0);
    #1;
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (ready_o[g] !== 1'b0) begin miscompares++; $display("FAIL raw_stall dut%0d got %b want 0", g, ready_o[g]); end
    end
    tick();
    vectors++;
    if (valid_o[0] !== 1'b0 || valid_o[1] !== 1'b0) begin
      miscompares++; $display("FAIL raw_no_issue got v0=%b v1=%b want 0 0", valid_o[0], valid_o[1]);
    end
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    #1;
    vectors++;
    if (ready_o[0] !== 1'b1) begin miscompares++; $display("FAIL raw_bypass_ready got %b want 1", ready_o[0]); end
    vectors++;
    if (ready_o[1] !== 1'b0) begin miscompares++; $display("FAIL raw_nobypass_ready got %b want 0", ready_o[1]); end
    tick();
    wb_en = 1'b0;
    valid[0] = 1'b0;
    vectors++;
    if (valid_o[0] !== 1'b1 || rs1_o[0] !== 32'd5 || rs2_o[0] !== 32'd5 || rd_o[0] !== 5'd2) begin
      miscompares++;
      $display("FAIL raw_bypass_data got v=%b rs1=%h rs2=%h rd=%0d want 1 5 5 2", valid_o[0], rs1_o[0], rs2_o[0], rd_o[0]);
    end
    vectors++;
    if (valid_o[1] !== 1'b0) begin miscompares++; $display("FAIL raw_nobypass_early got %b want 0", valid_o[1]); end
    #1;
    vectors++;
    if (ready_o[1] !== 1'b1) begin miscompares++; $display("FAIL raw_nobypass_late_ready got %b want 1", ready_o[1]); end
    tick();
    valid[1] = 1'b0;
    vectors++;
    if (valid_o[1] !== 1'b1 || rs1_o[1] !== 32'd5 || rs2_o[1] !== 32'd5) begin
      miscompares++;
      $display("FAIL raw_nobypass_data got v=%b rs1=%h rs2=%h want 1 5 5", valid_o[1], rs1_o[1], rs2_o[1]);
    end
    wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_branch_backpressure();
    inst = BEQ_M8; pc = 32'h200;
    set_valid(1'b1, 1'b1, 1'b1);
    rdy_in = 1'b0;
    tick();
    inst = ADDI_X3;
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (valid_o[g] !== 1'b1 || imm_o[g] !== 32'hFFFFFFF8 || br_o[g] !== 1'b1 || alu_o[g] !== 5'b10000 || rw_o[g] !== 1'b0) begin
        miscompares++;
        $display("FAIL branch_dec dut%0d got v=%b imm=%h br=%b alu=%b rw=%b want 1 fffffff8 1 10000 0",
                 g, valid_o[g], imm_o[g], br_o[g], alu_o[g], rw_o[g]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        vectors++;
        if (ready_o[g] !== 1'b0 || valid_o[g] !== 1'b1 || imm_o[g] !== 32'hFFFFFFF8 || pc_o[g] !== 32'h200) begin
          miscompares++;
          $display("FAIL backpressure_hold c%0d dut%0d got rdy=%b v=%b imm=%h pc=%h want 0 1 fffffff8 200",
                   c, g, ready_o[g], valid_o[g], imm_o[g], pc_o[g]);
        end
      end
    end
    set_valid(1'b0, 1'b0, 1'b0);
    rdy_in = 1'b1;
    tick();
    vectors++;
    if (valid_o[0] !== 1'b0) begin miscompares++; $display("FAIL backpressure_drain got %b want 0", valid_o[0]); end
  endtask

  task automatic test_flush();
    inst = ADDI_X1;
    set_valid(1'b1, 1'b1, 1'b1);
    rdy_in = 1'b0;
    tick();
    vectors++;
    if (valid_o[0] !== 1'b1 || rw_o[0] !== 1'b1) begin
      miscompares++; $display("FAIL flush_setup got v=%b rw=%b want 1 1", valid_o[0], rw_o[0]);
    end
    inst = ADDI_X3;
    flush = 1'b1;
    #1;
    vectors++;
    if (ready_o[0] !== 1'b0) begin miscompares++; $display("FAIL flush_ready got %b want 0", ready_o[0]); end
    tick();
    flush = 1'b0;
    set_valid(1'b0, 1'b0, 1'b0);
    rdy_in = 1'b1;
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (valid_o[g] !== 1'b0) begin miscompares++; $display("FAIL flush_valid dut%0d got %b want 0", g, valid_o[g]); end
    end
    inst = ADD_X2;
    #1;
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (ready_o[g] !== 1'b1) begin miscompares++; $display("FAIL flush_busy_clear dut%0d got %b want 1", g, ready_o[g]); end
    end
    inst = ADD_X4;
    #1;
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (ready_o[g] !== 1'b1) begin miscompares++; $display("FAIL flush_no_issue dut%0d got %b want 1", g, ready_o[g]); end
    end
  endtask

  task automatic test_rv32e();
    inst = ADDI_X17;
    set_valid(1'b1, 1'b1, 1'b1);
    tick();
    set_valid(1'b0, 1'b0, 1'b0);
    vectors++;
    if (valid_o[2] !== 1'b1 || ill_o[2] !== 1'b1 || rw_o[2] !== 1'b0) begin
      miscompares++; $display("FAIL rv32e_illegal got v=%b ill=%b rw=%b want 1 1 0", valid_o[2], ill_o[2], rw_o[2]);
    end
    vectors++;
    if (ill_o[0] !== 1'b0 || rw_o[0] !== 1'b1 || rd_o[0] !== 5'd17) begin
      miscompares++; $display("FAIL rv32i_x17 got ill=%b rw=%b rd=%0d want 0 1 17", ill_o[0], rw_o[0], rd_o[0]);
    end
    inst = ADD_X2;
    #1;
    vectors++;
    if (ready_o[2] !== 1'b1) begin miscompares++; $display("FAIL rv32e_no_busy got %b want 1", ready_o[2]); end
    tick();
  endtask

  task automatic test_reset_mid();
    inst = ADDI_X1;
    set_valid(1'b1, 1'b1, 1'b1);
    tick();
    set_valid(1'b0, 1'b0, 1'b0);
    vectors++;
    if (valid_o[0] !== 1'b1) begin miscompares++; $display("FAIL rstmid_setup got %b want 1", valid_o[0]); end
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (valid_o[g] !== 1'b0) begin miscompares++; $display("FAIL rstmid_async dut%0d got %b want 0", g, valid_o[g]); end
    end
    tick();
    rst_n = 1'b1;
    inst = ADD_X2;
    #1;
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (ready_o[g] !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy dut%0d got %b want 1", g, ready_o[g]); end
    end
    set_valid(1'b1, 1'b1, 1'b1);
    tick();
    set_valid(1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (valid_o[g] !== 1'b1 || rs1_o[g] !== 32'd5 || rs2_o[g] !== 32'd5) begin
        miscompares++;
        $display("FAIL rstmid_regs dut%0d got v=%b rs1=%h rs2=%h want 1 5 5", g, valid_o[g], rs1_o[g], rs2_o[g]);
      end
    end
  endtask

  initial begin
    set_valid(1'b0, 1'b0, 1'b0);
    inst = 32'h0; pc = 32'h0; flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; rdy_in = 1'b1;
    test_reset();
    test_decode();
    test_basic();
    test_raw();
    test_branch_backpressure();
    test_flush();
    test_rv32e();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
